// File: rtl/pwm_seq_pkg.sv
// Shared state encoding and duty helpers for the PWM duty sequencer.
// Helpers work on 64-bit values so any DUTY_W up to 64 can use them via a cast.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_STOPPING
  } seq_state_t;

  function automatic int idx_bits(input int num_steps);
    return $clog2(num_steps);
  endfunction

  function automatic logic [63:0] clamp_duty(input logic [63:0] val, input logic [63:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  // Move cur toward tgt by at most step; a zero step jumps straight to tgt.
  function automatic logic [63:0] ramp_next(input logic [63:0] cur, input logic [63:0] tgt,
                                            input logic [63:0] step);
    if (step == 64'd0) return tgt;
    if (cur < tgt) return ((tgt - cur) <= step) ? tgt : (cur + step);
    return ((cur - tgt) <= step) ? tgt : (cur - step);
  endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// Duty table: NUM_STEPS x DUTY_W register file, one synchronous write port,
// one combinational read port, contents cleared by async reset.
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int DUTY_W    = 32,
  localparam int IDX_W    = idx_bits(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DUTY_W-1:0] rd_data
);

  logic [DUTY_W-1:0] mem [NUM_STEPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Steps a duty table into the PWM, changing duty only on period boundaries.
// Define PWM_SEQ_RAMP_EN to add ramp_step and slew duty toward each target.
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int DUTY_W    = 32,
  parameter int PERIOD    = 1000,
  parameter int HOLD_W    = 16,
  localparam int IDX_W    = idx_bits(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic [HOLD_W-1:0] hold_periods,
  input  logic              period_done,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
`ifdef PWM_SEQ_RAMP_EN
  input  logic [DUTY_W-1:0] ramp_step,
`endif
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [IDX_W-1:0]  index,
  output logic              busy,
  output logic              done
);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              loop_q, loop_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  rd_addr;
  logic [DUTY_W-1:0] rd_data;
  logic [DUTY_W-1:0] entry;
  logic [DUTY_W-1:0] apply_val;
  logic [DUTY_W-1:0] toward_tgt;
  logic [DUTY_W-1:0] toward_zero;
  logic              at_target;

  pwm_seq_table #(
    .NUM_STEPS (NUM_STEPS),
    .DUTY_W    (DUTY_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The only fetches are entry 0 (arm / wrap) or the entry after ptr.
  assign rd_addr = (state_q == S_RUN && ptr_q != last_q) ? ptr_q + IDX_W'(1) : '0;
  assign entry   = DUTY_W'(clamp_duty(64'(rd_data), 64'(PERIOD)));

`ifdef PWM_SEQ_RAMP_EN
  logic [DUTY_W-1:0] target_q, target_d;

  assign apply_val   = DUTY_W'(ramp_next(64'(duty_q), 64'(entry), 64'(ramp_step)));
  assign toward_tgt  = DUTY_W'(ramp_next(64'(duty_q), 64'(target_q), 64'(ramp_step)));
  assign toward_zero = DUTY_W'(ramp_next(64'(duty_q), 64'd0, 64'(ramp_step)));
  assign at_target   = (duty_q == target_q);
`else
  assign apply_val   = entry;
  assign toward_tgt  = duty_q;
  assign toward_zero = '0;
  assign at_target   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    loop_d  = loop_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
`ifdef PWM_SEQ_RAMP_EN
    target_d = target_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_ARM;
          loop_d  = loop;
          last_d  = last_idx;
          hold_d  = (hold_periods == '0) ? HOLD_W'(1) : hold_periods;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_STOPPING;
        end else if (period_done) begin
          state_d = S_RUN;
          ptr_d   = '0;
          cnt_d   = HOLD_W'(1);
          duty_d  = apply_val;
`ifdef PWM_SEQ_RAMP_EN
          target_d = entry;
`endif
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_STOPPING;
        end else if (period_done) begin
          // Hold periods are only counted once the duty has settled on its target.
          if (!at_target) begin
            duty_d = toward_tgt;
          end else if (cnt_q < hold_q) begin
            cnt_d = cnt_q + HOLD_W'(1);
          end else if (ptr_q == last_q && !loop_q) begin
            state_d = S_IDLE;
            duty_d  = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d  = (ptr_q == last_q) ? '0 : ptr_q + IDX_W'(1);
            cnt_d  = HOLD_W'(1);
            duty_d = apply_val;
`ifdef PWM_SEQ_RAMP_EN
            target_d = entry;
`endif
          end
        end
      end
      S_STOPPING: begin
        if (period_done) begin
          duty_d = toward_zero;
          if (toward_zero == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      duty_q  <= '0;
      done_q  <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      target_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
`ifdef PWM_SEQ_RAMP_EN
      target_q <= target_d;
`endif
    end
  end

  assign duty_cycle = duty_q;
  assign index      = ptr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Sequences a programmable table of duty-cycle values into the PWM generator. Holds each table entry for a configured number of PWM periods, then advances, in one-shot or looping mode. All duty changes land only on PWM period boundaries, so the PWM never sees a duty update mid-period. Sits between the DutyCycle/index source and the PWM `DUTY_CYCLE` input; replaces the free-running index lookup when a timed profile is needed.

## Interface
- `NUM_STEPS`, 16, number of table entries (power of two, ≥2)
- `DUTY_W`, 32, duty value width, matches the PWM `DUTY_CYCLE` width
- `PERIOD`, 1000, PWM period in clk cycles; duty values clamp to this
- `HOLD_W`, 16, width of the hold-period counter
- `clk`  in  1  single system clock (same clock as the PWM)
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  1-cycle pulse; begins a sequence from entry 0
- `stop`  in  1  1-cycle pulse; aborts the sequence and drives duty to 0 at the next boundary
- `loop`  in  1  sampled on `start`; 1 = wrap to entry 0 after the last entry
- `last_idx`  in  clog2(NUM_STEPS)  index of the final active entry, sampled on `start`
- `hold_periods`  in  HOLD_W  PWM periods per entry, sampled on `start`; 0 is treated as 1
- `period_done`  in  1  1-cycle pulse from the PWM on the final clk of each period
- `wr_en`, `wr_addr`, `wr_data`  in  1 / clog2(NUM_STEPS) / DUTY_W  table write port
- `duty_cycle`  out  DUTY_W  registered duty to the PWM
- `index`  out  clog2(NUM_STEPS)  entry currently applied
- `busy`  out  1  high from ARM through RUN
- `done`  out  1  1-cycle pulse when a one-shot sequence completes

## Operation
- States: IDLE, ARM, RUN, STOPPING.
- IDLE: `start` → ARM. Latch `loop`, `last_idx`, and `max(hold_periods,1)`. Set ptr=0.
- ARM: on `period_done`, apply `table[0]` and go to RUN with hold counter = 1.
- RUN: on each `period_done`:
  - If hold counter < hold, increment it.
  - Else if ptr == `last_idx`: with loop, ptr=0 and apply `table[0]`; without loop, pulse `done`, set duty 0, go to IDLE.
  - Else ptr+1, apply `table[ptr+1]`, counter=1.
- `stop` in ARM or RUN → STOPPING. On the next `period_done`, duty=0, then IDLE. No `done` pulse.
- `stop` and `start` in the same cycle: stop wins. `start` while busy is ignored.
- Applied duty = min(entry, PERIOD).
- Table writes are accepted in any state. A write takes effect only when that entry is next fetched. A write to the current entry does not alter `duty_cycle`.
- `last_idx` ≥ NUM_STEPS cannot occur (width-limited). `index` wraps modulo NUM_STEPS.

## Timing
- Reset values: `duty_cycle`=0, `index`=0, `busy`=0, `done`=0, state IDLE. Table contents are reset to 0.
- `start` at cycle t → `busy`=1 at t+1.
- `duty_cycle` and `index` update exactly one clk after the `period_done` pulse. This is the first clk of the new period.
- `done` asserts in the same cycle the duty returns to 0. `busy` drops in that cycle too.
- Reset mid-sequence clears everything immediately (async). The sequence does not resume.
- `period_done` in IDLE is ignored.

## Configuration
- `PWM_SEQ_RAMP_EN` defined: adds input `ramp_step` (DUTY_W).
  - Instead of step-changing, `duty_cycle` moves toward the current target by at most `ramp_step` per `period_done`. It never overshoots.
  - Hold counting starts only once the target is reached. STOPPING ramps down to 0 before IDLE.
  - `ramp_step`=0 behaves as an immediate step.
- Not defined: the port is absent, and duty changes are immediate as described above.

## Structure
- `pwm_seq_pkg`: state enum, `IDX_W` = clog2(NUM_STEPS), duty clamp function.
- Sub-module `pwm_seq_table`: NUM_STEPS×DUTY_W register file, one synchronous write port, one combinational read port, async reset to 0.

## Test plan
- Load table {100,200,300,400}, last_idx=3, hold=2, loop=0, start → duty goes 100,100,200,200,300,300,400,400 on successive periods; `done` pulses; duty=0.
- Same table with loop=1 for 10 periods → sequence 100,100,200,…,400,400,100,100; `done` never pulses.
- Entry value 5000 with PERIOD=1000 → `duty_cycle`=1000.
- `stop` in the middle of a period while at 300 → duty stays 300 until `period_done`, then 0; `busy`=0; no `done`.
- `start`+`stop` in the same cycle from IDLE → remains IDLE; rewrite current entry 200→250 during RUN → 250 appears only on the next loop pass.
- Ramp build: ramp_step=50, table {0,200} → 0,50,100,150,200, then hold counted from 200. Async reset mid-ramp → all outputs 0 immediately.
